// File: rtl/axi_bridge_pkg.sv
// Shared definitions for the AXI-to-AXI-lite write bridge.
// Contents: AXI response and burst codes, write-bridge FSM state encoding.
// No logic; imported by the bridge top and its lane packer.
package axi_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Encoding 3'd7 is unused; the FSM treats it as IDLE.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WDATA     = 3'd1,
    ST_LITE      = 3'd2,
    ST_WF_B      = 3'd3,
    ST_RESP      = 3'd4,
    ST_ERR_DRAIN = 3'd5,
    ST_ERR_RESP  = 3'd6
  } wr_state_e;

endpackage

// File: rtl/axil_wr_lane_pack.sv
// Purpose: maps one AXI write beat onto the AXI-lite data/strobe lanes.
// Latency: combinational, zero cycles.
// Backpressure: none, pure datapath.
// Ports: addr selects the lane; axi_wdata/axi_wstrb in, axil_wdata/axil_wstrb out.
module axil_wr_lane_pack #(
  parameter int ADDR_WIDTH      = 32,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXIL_DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [AXI_DATA_WIDTH-1:0]    axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]  axi_wstrb,
  output logic [AXIL_DATA_WIDTH-1:0]   axil_wdata,
  output logic [AXIL_DATA_WIDTH/8-1:0] axil_wstrb
);

  localparam int AXI_BYTES  = AXI_DATA_WIDTH / 8;
  localparam int AXIL_BYTES = AXIL_DATA_WIDTH / 8;
  localparam int AXI_LSB    = $clog2(AXI_BYTES);
  localparam int AXIL_LSB   = $clog2(AXIL_BYTES);

  // Only the lane-select address bits matter here; the rest are folded away.
  logic unused_addr;
  assign unused_addr = ^addr;

  generate
    if (AXI_DATA_WIDTH > AXIL_DATA_WIDTH) begin : g_down
      // Wide AXI beat: pick the lite-sized lane the address points at.
      logic [AXI_LSB-AXIL_LSB-1:0] lane;
      logic [AXI_DATA_WIDTH-1:0]   data_shift;
      logic [AXI_BYTES-1:0]        strb_shift;
      assign lane       = addr[AXI_LSB-1:AXIL_LSB];
      assign data_shift = axi_wdata >> (lane * AXIL_DATA_WIDTH);
      assign strb_shift = axi_wstrb >> (lane * AXIL_BYTES);
      assign axil_wdata = data_shift[AXIL_DATA_WIDTH-1:0];
      assign axil_wstrb = strb_shift[AXIL_BYTES-1:0];
    end else if (AXI_DATA_WIDTH < AXIL_DATA_WIDTH) begin : g_up
      // Narrow AXI beat: copy data to every lane, enable only the addressed one.
      localparam int RATIO = AXIL_DATA_WIDTH / AXI_DATA_WIDTH;
      logic [AXIL_LSB-AXI_LSB-1:0] lane;
      assign lane       = addr[AXIL_LSB-1:AXI_LSB];
      assign axil_wdata = {RATIO{axi_wdata}};
      assign axil_wstrb = AXIL_BYTES'(axi_wstrb) << (lane * AXI_BYTES);
    end else begin : g_pass
      assign axil_wdata = axi_wdata;
      assign axil_wstrb = axi_wstrb;
    end
  endgenerate

endmodule

// File: rtl/axi_axil_bridge_wr.sv
// Purpose: converts single-beat AXI writes into AXI-lite writes; bursts get SLVERR.
// Latency: AW hs cycle 0, W hs 1, lite AW/W 2, lite B 3, s_axi_bvalid 4 (zero-wait peers).
// Backpressure: one transaction in flight; AW/W ready only in their own states.
// Ports: s_axi_aw*/w*/b* AXI slave write side, m_axil_aw*/w*/b* AXI-lite master side.
module axi_axil_bridge_wr
  import axi_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_ID_WIDTH    = 8,
  parameter int AXIL_DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AXI_ID_WIDTH-1:0]      s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic [7:0]                   s_axi_awlen,
  input  logic [1:0]                   s_axi_awburst,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]    s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]  s_axi_wstrb,
  input  logic                         s_axi_wlast,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [AXI_ID_WIDTH-1:0]      s_axi_bid,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  output logic [ADDR_WIDTH-1:0]        m_axil_awaddr,
  output logic                         m_axil_awvalid,
  input  logic                         m_axil_awready,
  output logic [AXIL_DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                         m_axil_wvalid,
  input  logic                         m_axil_wready,
  input  logic [1:0]                   m_axil_bresp,
  input  logic                         m_axil_bvalid,
  output logic                         m_axil_bready
);

  wr_state_e                   state_q, state_d;
  logic [AXI_ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic [1:0]                  bresp_q;
  logic                        aw_done, w_done;
  logic                        lite_aw_hs, lite_w_hs;

  // Burst type never changes the outcome: length alone decides accept vs. reject.
  logic unused_burst;
  assign unused_burst = ^s_axi_awburst;

  assign lite_aw_hs = m_axil_awvalid && m_axil_awready;
  assign lite_w_hs  = m_axil_wvalid && m_axil_wready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (s_axi_awvalid)
                      state_d = (s_axi_awlen == 8'd0) ? ST_WDATA : ST_ERR_DRAIN;
      ST_WDATA:     if (s_axi_wvalid) state_d = ST_LITE;
      // Lite AW and W complete independently; leave once both have.
      ST_LITE:      if ((aw_done || lite_aw_hs) && (w_done || lite_w_hs))
                      state_d = ST_WF_B;
      ST_WF_B:      if (m_axil_bvalid) state_d = ST_RESP;
      ST_RESP:      if (s_axi_bready) state_d = ST_IDLE;
      ST_ERR_DRAIN: if (s_axi_wvalid && s_axi_wlast) state_d = ST_ERR_RESP;
      ST_ERR_RESP:  if (s_axi_bready) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    s_axi_awready  = 1'b0;
    s_axi_wready   = 1'b0;
    s_axi_bvalid   = 1'b0;
    s_axi_bid      = '0;
    s_axi_bresp    = RESP_OKAY;
    m_axil_awvalid = 1'b0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    case (state_q)
      ST_IDLE:      s_axi_awready = 1'b1;
      ST_WDATA:     s_axi_wready  = 1'b1;
      ST_LITE: begin
        m_axil_awvalid = !aw_done;
        m_axil_wvalid  = !w_done;
      end
      ST_WF_B:      m_axil_bready = 1'b1;
      ST_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bid    = id_q;
        s_axi_bresp  = bresp_q;
      end
      ST_ERR_DRAIN: s_axi_wready = 1'b1;
      ST_ERR_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bid    = id_q;
        s_axi_bresp  = RESP_SLVERR;
      end
      default: ;
    endcase
  end

  // Captured transaction context
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= RESP_OKAY;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && s_axi_awvalid) begin
        id_q   <= s_axi_awid;
        addr_q <= s_axi_awaddr;
      end
      if (state_q == ST_WDATA && s_axi_wvalid) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (lite_aw_hs) aw_done <= 1'b1;
      if (lite_w_hs)  w_done  <= 1'b1;
      if (state_q == ST_WF_B && m_axil_bvalid) bresp_q <= m_axil_bresp;
    end
  end

  // Address goes out unmodified and held in a register, so it is stable while valid.
  assign m_axil_awaddr = addr_q;

  axil_wr_lane_pack #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .AXI_DATA_WIDTH  (AXI_DATA_WIDTH),
    .AXIL_DATA_WIDTH (AXIL_DATA_WIDTH)
  ) u_lane_pack (
    .addr       (addr_q),
    .axi_wdata  (wdata_q),
    .axi_wstrb  (wstrb_q),
    .axil_wdata (m_axil_wdata),
    .axil_wstrb (m_axil_wstrb)
  );

endmodule

// File: tb/tb_axi_axil_bridge_wr.sv
// Directed bench for axi_axil_bridge_wr: a 32/32 instance and a 64->32 instance.
// Inputs change 1 time unit after the rising edge; outputs checked in that window.
module tb_axi_axil_bridge_wr;
  import axi_bridge_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- 32/32 instance ----------------
  logic [7:0]  s_awid = '0;
  logic [31:0] s_awaddr = '0;
  logic [7:0]  s_awlen = '0;
  logic [1:0]  s_awburst = BURST_INCR;
  logic        s_awvalid = 1'b0, s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wlast = 1'b0, s_wvalid = 1'b0, s_wready;
  logic [7:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready = 1'b1;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready = 1'b1, m_wvalid, m_wready = 1'b1;
  logic [1:0]  m_bresp = '0;
  logic        m_bvalid = 1'b0, m_bready;

  axi_axil_bridge_wr #(.ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(8), .AXIL_DATA_WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_awid), .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen), .s_axi_awburst(s_awburst),
    .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
    .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wlast(s_wlast),
    .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
    .s_axi_bid(s_bid), .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
    .m_axil_awaddr(m_awaddr), .m_axil_awvalid(m_awvalid), .m_axil_awready(m_awready),
    .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready),
    .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready)
  );

  // Lite handshake counters, sampled mid-cycle where everything is settled.
  int aw_cnt = 0, w_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (m_awvalid && m_awready) aw_cnt++;
      if (m_wvalid && m_wready)   w_cnt++;
    end
  end

  // ---------------- 64->32 instance ----------------
  logic [7:0]  x_awid = '0;
  logic [31:0] x_awaddr = '0;
  logic [7:0]  x_awlen = '0;
  logic [1:0]  x_awburst = BURST_INCR;
  logic        x_awvalid = 1'b0, x_awready;
  logic [63:0] x_wdata = '0;
  logic [7:0]  x_wstrb = '0;
  logic        x_wlast = 1'b0, x_wvalid = 1'b0, x_wready;
  logic [7:0]  x_bid;
  logic [1:0]  x_bresp;
  logic        x_bvalid, x_bready = 1'b1;
  logic [31:0] xm_awaddr, xm_wdata;
  logic [3:0]  xm_wstrb;
  logic        xm_awvalid, xm_wvalid, xm_bready;
  logic        xm_bvalid = 1'b0;

  axi_axil_bridge_wr #(.ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(8), .AXIL_DATA_WIDTH(32)) u_dut64 (
    .clk(clk), .rst(rst),
    .s_axi_awid(x_awid), .s_axi_awaddr(x_awaddr), .s_axi_awlen(x_awlen), .s_axi_awburst(x_awburst),
    .s_axi_awvalid(x_awvalid), .s_axi_awready(x_awready),
    .s_axi_wdata(x_wdata), .s_axi_wstrb(x_wstrb), .s_axi_wlast(x_wlast),
    .s_axi_wvalid(x_wvalid), .s_axi_wready(x_wready),
    .s_axi_bid(x_bid), .s_axi_bresp(x_bresp), .s_axi_bvalid(x_bvalid), .s_axi_bready(x_bready),
    .m_axil_awaddr(xm_awaddr), .m_axil_awvalid(xm_awvalid), .m_axil_awready(1'b1),
    .m_axil_wdata(xm_wdata), .m_axil_wstrb(xm_wstrb), .m_axil_wvalid(xm_wvalid), .m_axil_wready(1'b1),
    .m_axil_bresp(RESP_OKAY), .m_axil_bvalid(xm_bvalid), .m_axil_bready(xm_bready)
  );

  // Present one single-beat (or burst) AW and complete its handshake.
  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awvalid = 1'b1;
    step();
    s_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    s_wdata = data; s_wstrb = strb; s_wlast = 1'b1; s_wvalid = 1'b1;
    step();
    s_wvalid = 1'b0; s_wlast = 1'b0;
  endtask

  int aw_base, w_base;

  initial begin
    // ---- reset ----
    step(); step();
    check("rst_awready_during", {63'd0, s_awready}, 64'd1);
    rst = 1'b0;
    check("rst_awready", {63'd0, s_awready}, 64'd1);
    check("rst_wready", {63'd0, s_wready}, 64'd0);
    check("rst_bvalid", {63'd0, s_bvalid}, 64'd0);
    check("rst_bid", {56'd0, s_bid}, 64'd0);
    check("rst_bresp", {62'd0, s_bresp}, 64'd0);
    check("rst_lite_awvalid", {63'd0, m_awvalid}, 64'd0);
    check("rst_lite_wvalid", {63'd0, m_wvalid}, 64'd0);
    check("rst_lite_bready", {63'd0, m_bready}, 64'd0);

    // ---- single write, zero-wait lite slave, cycle-accurate ----
    check("t1_c0_awready", {63'd0, s_awready}, 64'd1);
    send_aw(8'h5A, 32'h100, 8'd0);                      // cycle 0
    check("t1_c1_awready", {63'd0, s_awready}, 64'd0);
    check("t1_c1_wready", {63'd0, s_wready}, 64'd1);
    send_w(32'hDEADBEEF, 4'hF);                         // cycle 1
    check("t1_c2_awvalid", {63'd0, m_awvalid}, 64'd1);
    check("t1_c2_wvalid", {63'd0, m_wvalid}, 64'd1);
    check("t1_c2_awaddr", {32'd0, m_awaddr}, 64'h100);
    check("t1_c2_wdata", {32'd0, m_wdata}, 64'hDEADBEEF);
    check("t1_c2_wstrb", {60'd0, m_wstrb}, 64'hF);
    step();                                             // cycle 2: lite AW/W
    check("t1_c3_awvalid", {63'd0, m_awvalid}, 64'd0);
    check("t1_c3_wvalid", {63'd0, m_wvalid}, 64'd0);
    check("t1_c3_bready", {63'd0, m_bready}, 64'd1);
    check("t1_c3_bvalid_early", {63'd0, s_bvalid}, 64'd0);
    m_bvalid = 1'b1; m_bresp = RESP_OKAY;
    step();                                             // cycle 3: lite B
    m_bvalid = 1'b0;
    check("t1_c4_bvalid", {63'd0, s_bvalid}, 64'd1);
    check("t1_c4_bid", {56'd0, s_bid}, 64'h5A);
    check("t1_c4_bresp", {62'd0, s_bresp}, 64'd0);
    step();                                             // cycle 4: B handshake
    check("t1_c5_awready", {63'd0, s_awready}, 64'd1);
    check("t1_c5_bvalid", {63'd0, s_bvalid}, 64'd0);

    // ---- lite AW and W accepted 3 cycles apart, both orders ----
    for (int o = 0; o < 2; o++) begin
      aw_base = aw_cnt; w_base = w_cnt;
      m_awready = (o == 0); m_wready = (o == 1);
      send_aw((o == 0) ? 8'h33 : 8'h44, (o == 0) ? 32'h200 : 32'h300, 8'd0);
      send_w(32'hCAFEF00D, 4'h3);
      check($sformatf("t2_%0d_entry_awvalid", o), {63'd0, m_awvalid}, 64'd1);
      check($sformatf("t2_%0d_entry_wvalid", o), {63'd0, m_wvalid}, 64'd1);
      for (int c = 0; c < 3; c++) begin
        step();
        check($sformatf("t2_%0d_wait%0d_awvalid", o, c), {63'd0, m_awvalid}, (o == 0) ? 64'd0 : 64'd1);
        check($sformatf("t2_%0d_wait%0d_wvalid", o, c), {63'd0, m_wvalid}, (o == 0) ? 64'd1 : 64'd0);
        check($sformatf("t2_%0d_wait%0d_bready", o, c), {63'd0, m_bready}, 64'd0);
      end
      m_awready = 1'b1; m_wready = 1'b1;
      step();
      check($sformatf("t2_%0d_done_awvalid", o), {63'd0, m_awvalid}, 64'd0);
      check($sformatf("t2_%0d_done_wvalid", o), {63'd0, m_wvalid}, 64'd0);
      check($sformatf("t2_%0d_done_bready", o), {63'd0, m_bready}, 64'd1);
      m_bvalid = 1'b1; m_bresp = (o == 0) ? RESP_SLVERR : RESP_OKAY;
      step();
      m_bvalid = 1'b0;
      check($sformatf("t2_%0d_bvalid", o), {63'd0, s_bvalid}, 64'd1);
      check($sformatf("t2_%0d_bresp", o), {62'd0, s_bresp}, (o == 0) ? 64'd2 : 64'd0);
      check($sformatf("t2_%0d_bid", o), {56'd0, s_bid}, (o == 0) ? 64'h33 : 64'h44);
      step();
      check($sformatf("t2_%0d_aw_count", o), 64'(aw_cnt - aw_base), 64'd1);
      check($sformatf("t2_%0d_w_count", o), 64'(w_cnt - w_base), 64'd1);
    end

    // ---- 4-beat INCR burst is drained and answered with SLVERR ----
    aw_base = aw_cnt; w_base = w_cnt;
    send_aw(8'h77, 32'h400, 8'd3);
    check("t3_awready_busy", {63'd0, s_awready}, 64'd0);
    for (int b = 0; b < 4; b++) begin
      s_wdata = 32'h1000 + b; s_wstrb = 4'hF; s_wlast = (b == 3); s_wvalid = 1'b1;
      check($sformatf("t3_beat%0d_wready", b), {63'd0, s_wready}, 64'd1);
      check($sformatf("t3_beat%0d_lite_valid", b), {62'd0, m_awvalid, m_wvalid}, 64'd0);
      check($sformatf("t3_beat%0d_bvalid", b), {63'd0, s_bvalid}, 64'd0);
      step();
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    check("t3_bvalid", {63'd0, s_bvalid}, 64'd1);
    check("t3_bresp", {62'd0, s_bresp}, 64'd2);
    check("t3_bid", {56'd0, s_bid}, 64'h77);
    check("t3_wready_after", {63'd0, s_wready}, 64'd0);
    step();
    check("t3_idle_awready", {63'd0, s_awready}, 64'd1);
    check("t3_no_lite_aw", 64'(aw_cnt - aw_base), 64'd0);
    check("t3_no_lite_w", 64'(w_cnt - w_base), 64'd0);

    // ---- reset while waiting for lite B, stale lite B afterwards ----
    send_aw(8'h99, 32'h500, 8'd0);
    send_w(32'h12345678, 4'hF);
    step();
    check("t4_in_wfb_bready", {63'd0, m_bready}, 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_bvalid = 1'b1; m_bresp = RESP_SLVERR;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("t4_c%0d_bvalid", c), {63'd0, s_bvalid}, 64'd0);
      check($sformatf("t4_c%0d_lite_bready", c), {63'd0, m_bready}, 64'd0);
      check($sformatf("t4_c%0d_awready", c), {63'd0, s_awready}, 64'd1);
      check($sformatf("t4_c%0d_bid_bresp", c), {54'd0, s_bid, s_bresp}, 64'd0);
      check($sformatf("t4_c%0d_lite_valid", c), {62'd0, m_awvalid, m_wvalid}, 64'd0);
      step();
    end
    m_bvalid = 1'b0;

    // ---- 64-bit AXI to 32-bit lite, upper lane ----
    x_awid = 8'h12; x_awaddr = 32'h104; x_awlen = 8'd0; x_awvalid = 1'b1;
    step();
    x_awvalid = 1'b0;
    x_wdata = 64'h11223344_55667788; x_wstrb = 8'hF0; x_wlast = 1'b1; x_wvalid = 1'b1;
    check("t5_wready", {63'd0, x_wready}, 64'd1);
    step();
    x_wvalid = 1'b0;
    check("t5_awvalid", {63'd0, xm_awvalid}, 64'd1);
    check("t5_awaddr", {32'd0, xm_awaddr}, 64'h104);
    check("t5_wdata", {32'd0, xm_wdata}, 64'h11223344);
    check("t5_wstrb", {60'd0, xm_wstrb}, 64'hF);
    step();
    xm_bvalid = 1'b1;
    step();
    xm_bvalid = 1'b0;
    check("t5_bvalid", {63'd0, x_bvalid}, 64'd1);
    check("t5_bid", {56'd0, x_bid}, 64'h12);
    check("t5_bresp", {62'd0, x_bresp}, 64'd0);
    step();
    check("t5_idle", {63'd0, x_awready}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_axil_bridge_wr.md
AXI_AXIL_BRIDGE_WR -- requirements
Module: axi_axil_bridge_wr

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width in bits.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, AXI slave data width (power of 2, >=8).
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 8, AXI ID width.
REQ-004 SHALL have parameter AXIL_DATA_WIDTH, default 32, AXI-lite master data width (power of 2, >=8).
REQ-005 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port s_axi_awid  in  AXI_ID_WIDTH  write ID.
REQ-008 SHALL have port s_axi_awaddr  in  ADDR_WIDTH  write address.
REQ-009 SHALL have port s_axi_awlen  in  8  burst length minus one.
REQ-010 SHALL have port s_axi_awburst  in  2  burst type.
REQ-011 SHALL have port s_axi_awvalid  in  1  AW valid.
REQ-012 SHALL have port s_axi_awready  out  1  AW ready.
REQ-013 SHALL have port s_axi_wdata  in  AXI_DATA_WIDTH  write data.
REQ-014 SHALL have port s_axi_wstrb  in  AXI_DATA_WIDTH/8  byte strobes.
REQ-015 SHALL have port s_axi_wlast  in  1  last beat.
REQ-016 SHALL have port s_axi_wvalid  in  1  W valid.
REQ-017 SHALL have port s_axi_wready  out  1  W ready.
REQ-018 SHALL have port s_axi_bid  out  AXI_ID_WIDTH  response ID.
REQ-019 SHALL have port s_axi_bresp  out  2  write response.
REQ-020 SHALL have port s_axi_bvalid  out  1  B valid.
REQ-021 SHALL have port s_axi_bready  in  1  B ready.
REQ-022 SHALL have port m_axil_awaddr  out  ADDR_WIDTH  lite write address.
REQ-023 SHALL have port m_axil_awvalid  out  1  lite AW valid.
REQ-024 SHALL have port m_axil_awready  in  1  lite AW ready.
REQ-025 SHALL have port m_axil_wdata  out  AXIL_DATA_WIDTH  lite write data.
REQ-026 SHALL have port m_axil_wstrb  out  AXIL_DATA_WIDTH/8  lite strobes.
REQ-027 SHALL have port m_axil_wvalid  out  1  lite W valid.
REQ-028 SHALL have port m_axil_wready  in  1  lite W ready.
REQ-029 SHALL have port m_axil_bresp  in  2  lite response.
REQ-030 SHALL have port m_axil_bvalid  in  1  lite B valid.
REQ-031 SHALL have port m_axil_bready  out  1  lite B ready.

Function
REQ-032 SHALL run FSM IDLE, WDATA, LITE, WF_B, RESP, ERR_DRAIN, ERR_RESP, one transaction in flight; unknown encoding -> IDLE.
REQ-033 IDLE: awready=1; on AW handshake capture id/addr; live awlen==0 -> WDATA, else (any burst) -> ERR_DRAIN.
REQ-034 WDATA: wready=1; on W handshake capture wdata/wstrb -> LITE; awready and wready never high together.
REQ-035 LITE: m_axil_awvalid and m_axil_wvalid high from entry, each drops the cycle after its own handshake (either order, same cycle allowed); both done -> WF_B; m_axil_awaddr = captured addr unmodified, stable while valid.
REQ-036 WF_B: m_axil_bready=1; on lite B handshake capture bresp -> RESP; RESP: s_axi_bvalid=1, bid=captured id, bresp=captured bresp, bready -> IDLE.
REQ-037 ERR_DRAIN: wready=1, discard beats until wvalid&wlast -> ERR_RESP (bvalid=1, bresp=2'b10, bid=captured id) -> IDLE on bready; no lite traffic issued.
REQ-038 Width: AXI wider -> lane k=addr[log2(AXI_DATA_WIDTH/8)-1:log2(AXIL_DATA_WIDTH/8)], wdata/wstrb shifted right by k lanes; AXI narrower -> wdata replicated, wstrb shifted left by addr[log2(AXIL_DATA_WIDTH/8)-1:log2(AXI_DATA_WIDTH/8)]*AXI_DATA_WIDTH/8; equal -> pass-through.
REQ-039 Latency with zero-wait peers: AW hs cycle 0, W hs 1, lite AW/W hs 2, lite B hs 3, s_axi_bvalid cycle 4; IDLE again cycle 5.

Reset
REQ-040 rst at posedge clk SHALL force IDLE: all valid/ready outputs 0 except s_axi_awready=1 after release, bresp/bid 0; mid-transaction reset abandons transfer, later lite responses are ignored until new transaction.

Structure
REQ-041 Package axi_bridge_pkg SHALL hold RESP_OKAY=2'b00, RESP_SLVERR=2'b10, BURST_INCR=2'b01, FSM state encodings.
REQ-042 Combinational sub-module axil_wr_lane_pack SHALL implement REQ-038.

Verification
REQ-043 32/32: awaddr=0x100, awlen=0, wdata=0xDEADBEEF, wstrb=0xF -> lite addr 0x100, data 0xDEADBEEF, strb 0xF; lite bresp 0 -> s_axi_bresp 0, bid echoed, bvalid at cycle 4.
REQ-044 64->32: awaddr=0x104, wdata=0x11223344_55667788, wstrb=0xF0 -> lite wdata 0x11223344, wstrb 0xF.
REQ-045 awlen=3 INCR, 4 W beats with wlast on 4th -> wready on all 4, no lite valid, bresp 2'b10 after last beat.
REQ-046 lite awready 3 cycles before wready, then reverse -> each valid drops independently, exactly one lite write; lite bresp 2'b10 forwarded.
REQ-047 rst asserted in WF_B, lite bvalid afterward -> outputs per REQ-040, no s_axi_bvalid.
